// File: rtl/ctrl_sequencer.sv
// Purpose : LC-3b indirect load/store (LDI/STI) memory sequencer; other opcodes pass straight through.
// Latency : 1 cycle transfer->out_valid for non-indirect ops, 3 cycles for LDI/STI with same-cycle mem_resp.
// Backpres: accepts only in IDLE (in_ready); holds DONE/ERR results until out_ready; stall high while busy.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake; opcode, addr_in, st_data captured on transfer
//   mem_read/mem_write         memory strobes, never both high
//   mem_addr/mem_wdata         access address (bit 0 forced low) and store data
//   mem_rdata/mem_resp         read data and access-complete from memory
//   out_valid/out_ready        result handshake; out_data (LDI value, else 0), out_err (timeout)
//   stall                      pipeline hold, high in every state except IDLE
//
// Configuration macro: CTRL_SEQ_TIMEOUT_EN
//   defined   -> per-access wait counter; MAX_WAIT cycles without mem_resp ends in ERR
//   undefined -> no counter, waits are unbounded, ERR unreachable, out_err tied low

module ctrl_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  // request side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] st_data,
  // memory side
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             stall
);

  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;

  // Elaboration-time guard on the parameter ranges the datapath relies on.
  if (MAX_WAIT < 1 || MAX_WAIT > 65535) begin : g_bad_max_wait
    $error("ctrl_sequencer: MAX_WAIT must be in 1..65535");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("ctrl_sequencer: WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PTR_RD = 3'd1,
    FIN_RD = 3'd2,
    FIN_WR = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;      // pointer location from EX
  logic [WIDTH-1:0] st_data_q, st_data_d;
  logic             is_ldi_q, is_ldi_d;  // selects FIN_RD vs FIN_WR after the pointer read
  logic [WIDTH-1:0] ptr_q, ptr_d;        // pointer fetched in PTR_RD
  logic [WIDTH-1:0] rdata_q, rdata_d;    // LDI result, zero for every other request

  logic             wait_expired;        // current access has used up its wait budget
  logic             in_access;

  // Word-aligned views of the two addresses; bit 0 of the raw values is never driven out.
  logic [WIDTH-1:0] addr_word;
  logic [WIDTH-1:0] ptr_word;
  logic             unused_lsbs;

  assign addr_word   = {addr_q[WIDTH-1:1], 1'b0};
  assign ptr_word    = {ptr_q[WIDTH-1:1], 1'b0};
  assign unused_lsbs = addr_q[0] ^ ptr_q[0];

  assign in_access = (state_q == PTR_RD) || (state_q == FIN_RD) || (state_q == FIN_WR);

  // ---------------------------------------------------------------------------
  // Optional access timeout
  // ---------------------------------------------------------------------------
`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(MAX_WAIT - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  // The counter value seen in a cycle is the number of earlier unanswered
  // cycles in this access, so the budget is spent when this cycle is the
  // MAX_WAIT-th one and still has no response. A response in that same
  // cycle is checked first in the FSM and therefore wins.
  assign wait_expired = in_access && !mem_resp && (wait_cnt_q == WaitLast);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      // Entering a new state (including the next access) restarts the count.
      wait_cnt_d = '0;
    end else if (in_access && !mem_resp) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      st_data_q <= '0;
      is_ldi_q  <= 1'b0;
      ptr_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      st_data_q <= st_data_d;
      is_ldi_q  <= is_ldi_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. All memory and result outputs are decoded from the
  // registered state, so an asynchronous reset drops them immediately and
  // they stay stable for as long as an access is waiting.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    st_data_d = st_data_q;
    is_ldi_d  = is_ldi_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;

    in_ready  = 1'b0;
    stall     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    out_err   = 1'b0;
    out_data  = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        stall    = 1'b0;
        if (in_valid) begin
          addr_d    = addr_in;
          st_data_d = st_data;
          is_ldi_d  = (opcode == OpLdi);
          // Cleared here so STI and pass-through results report zero.
          rdata_d   = '0;
          if ((opcode == OpLdi) || (opcode == OpSti)) begin
            state_d = PTR_RD;
          end else begin
            state_d = DONE;
          end
        end
      end

      PTR_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_word;
        if (mem_resp) begin
          ptr_d   = mem_rdata;
          state_d = is_ldi_q ? FIN_RD : FIN_WR;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end

      FIN_RD: begin
        mem_read = 1'b1;
        mem_addr = ptr_word;
        if (mem_resp) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end

      FIN_WR: begin
        mem_write = 1'b1;
        mem_addr  = ptr_word;
        mem_wdata = st_data_q;
        if (mem_resp) begin
          state_d = DONE;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        out_data  = rdata_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      ERR: begin
        out_valid = 1'b1;
        out_err   = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    in_ready == !stall);

  a_err_only_invalid: assert property (@(posedge clk) disable iff (rst)
    out_err |-> (out_valid && (out_data == '0)));

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] addr_in;
  logic [15:0] st_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic        stall;

  int n_checks = 0;
  int n_fails  = 0;

  // Memory responder: answers once a strobe has been waiting resp_delay cycles
  // (0 = same cycle, negative = never); resp_force injects a stray pulse.
  int   resp_delay;
  logic resp_force;
  int   strobe_cycles;

  // Access log
  logic [15:0] rd_addr [16];
  int          rd_n = 0;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  int          wr_n = 0;

  ctrl_sequencer #(.WIDTH(16), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .addr_in   (addr_in),
    .st_data   (st_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed memory image
  always_comb begin
    mem_rdata = 16'h0000;
    case (mem_addr)
      16'h3000: mem_rdata = 16'h4000;
      16'h4000: mem_rdata = 16'hBEEF;
      16'h2000: mem_rdata = 16'h5003;
      default:  mem_rdata = 16'h0000;
    endcase
  end

  assign mem_resp = resp_force ||
                    ((mem_read || mem_write) && (resp_delay >= 0) && (strobe_cycles >= resp_delay));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_cycles <= 0;
    end else if (!(mem_read || mem_write) || mem_resp) begin
      strobe_cycles <= 0;
    end else begin
      strobe_cycles <= strobe_cycles + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_read && mem_resp) begin
        rd_addr[rd_n % 16] <= mem_addr;
        rd_n <= rd_n + 1;
      end
      if (mem_write && mem_resp) begin
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
        wr_n    <= wr_n + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    check_eq("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode   = op;
    addr_in  = a;
    st_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = 4'h0;
    addr_in  = 16'h0;
    st_data  = 16'h0;
  endtask

  // Latency counts clock edges from the transfer edge (inclusive) to out_valid.
  task automatic wait_out(input int max_cyc, output int lat);
    lat = 1;
    while (!out_valid && lat < max_cyc) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("out_valid_within_budget", 32'(out_valid), 32'd1);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("back_to_idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("back_to_idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int wbase;

    rst        = 1'b1;
    in_valid   = 1'b0;
    opcode     = 4'h0;
    addr_in    = 16'h0;
    st_data    = 16'h0;
    out_ready  = 1'b0;
    resp_delay = 0;
    resp_force = 1'b0;

    // ---- reset state ----
    #12;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_stall",     32'(stall),     32'd0);
    check_eq("rst_mem_read",  32'(mem_read),  32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr),  32'h0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_err",   32'(out_err),   32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- LDI through 3001 -> 3000 -> 4000 -> BEEF ----
    base = rd_n;
    send(4'b1010, 16'h3001, 16'h0);
    wait_out(20, lat);
    check_eq("ldi_latency",  32'(lat),               32'd3);
    check_eq("ldi_rd0",      32'(rd_addr[base % 16]), 32'h3000);
    check_eq("ldi_rd1",      32'(rd_addr[(base + 1) % 16]), 32'h4000);
    check_eq("ldi_rd_count", 32'(rd_n - base),       32'd2);
    check_eq("ldi_data",     32'(out_data),          32'hBEEF);
    check_eq("ldi_err",      32'(out_err),           32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("ldi_hold_valid", 32'(out_valid), 32'd1);
      check_eq("ldi_hold_data",  32'(out_data),  32'hBEEF);
      check_eq("ldi_hold_strobes", 32'({mem_read, mem_write}), 32'd0);
    end
    accept();

    // ---- STI: pointer at 2000 is 5003, store 1234 to 5002 ----
    base  = rd_n;
    wbase = wr_n;
    send(4'b1011, 16'h2000, 16'h1234);
    wait_out(20, lat);
    check_eq("sti_latency",  32'(lat),                32'd3);
    check_eq("sti_rd0",      32'(rd_addr[base % 16]), 32'h2000);
    check_eq("sti_wr_count", 32'(wr_n - wbase),       32'd1);
    check_eq("sti_wr_addr",  32'(wr_addr),            32'h5002);
    check_eq("sti_wr_data",  32'(wr_data),            32'h1234);
    check_eq("sti_out_data", 32'(out_data),           32'h0);
    accept();

    // ---- ADD: no memory access, held result under backpressure ----
    base  = rd_n;
    wbase = wr_n;
    send(4'b0001, 16'h3001, 16'hAAAA);
    wait_out(20, lat);
    check_eq("add_latency",  32'(lat),      32'd1);
    check_eq("add_out_data", 32'(out_data), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("add_hold_valid",    32'(out_valid), 32'd1);
      check_eq("add_hold_stall",    32'(stall),     32'd1);
      check_eq("add_hold_in_ready", 32'(in_ready),  32'd0);
      check_eq("add_hold_strobes",  32'({mem_read, mem_write}), 32'd0);
      @(posedge clk);
      #1;
    end
    check_eq("add_no_reads",  32'(rd_n - base),  32'd0);
    check_eq("add_no_writes", 32'(wr_n - wbase), 32'd0);
    accept();

    // ---- LDI with the response arriving in the 4th waiting cycle ----
    resp_delay = 3;
    send(4'b1010, 16'h3001, 16'h0);
    wait_out(40, lat);
    check_eq("slow_ldi_latency", 32'(lat),      32'd9);
    check_eq("slow_ldi_err",     32'(out_err),  32'd0);
    check_eq("slow_ldi_data",    32'(out_data), 32'hBEEF);
    accept();

    // ---- LDI with no response in PTR_RD ----
    resp_delay = -1;
    send(4'b1010, 16'h3001, 16'h0);
`ifdef CTRL_SEQ_TIMEOUT_EN
    wait_out(40, lat);
    check_eq("timeout_latency", 32'(lat),      32'd5);
    check_eq("timeout_err",     32'(out_err),  32'd1);
    check_eq("timeout_data",    32'(out_data), 32'h0);
    check_eq("timeout_strobes", 32'({mem_read, mem_write}), 32'd0);
    accept();
    check_eq("timeout_err_clear", 32'(out_err), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("unbounded_no_valid", 32'(out_valid), 32'd0);
    check_eq("unbounded_read",     32'(mem_read),  32'd1);
    check_eq("unbounded_addr",     32'(mem_addr),  32'h3000);
    check_eq("unbounded_err",      32'(out_err),   32'd0);
    @(negedge clk);
    resp_delay = 0;
    wait_out(20, lat);
    check_eq("unbounded_finish_lat", 32'(lat),      32'd3);
    check_eq("unbounded_data",       32'(out_data), 32'hBEEF);
    check_eq("unbounded_err_end",    32'(out_err),  32'd0);
    accept();
`endif

    // ---- asynchronous reset in the middle of FIN_WR ----
    resp_delay = 0;
    wbase = wr_n;
    send(4'b1011, 16'h2000, 16'h1234);
    @(posedge clk);
    #1;
    resp_delay = -1;
    check_eq("abort_fin_wr_write", 32'(mem_write), 32'd1);
    check_eq("abort_fin_wr_addr",  32'(mem_addr),  32'h5002);
    check_eq("abort_fin_wr_wdata", 32'(mem_wdata), 32'h1234);
    @(posedge clk);
    #1;
    check_eq("abort_write_stable", 32'(mem_write), 32'd1);
    check_eq("abort_addr_stable",  32'(mem_addr),  32'h5002);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_write_drop",  32'(mem_write), 32'd0);
    check_eq("abort_in_ready",    32'(in_ready),  32'd1);
    check_eq("abort_stall",       32'(stall),     32'd0);
    check_eq("abort_mem_addr",    32'(mem_addr),  32'h0);
    check_eq("abort_mem_wdata",   32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    resp_delay = 0;
    resp_force = 1'b1;
    @(posedge clk);
    #1;
    resp_force = 1'b0;
    check_eq("late_resp_out_valid", 32'(out_valid), 32'd0);
    check_eq("late_resp_in_ready",  32'(in_ready),  32'd1);
    check_eq("late_resp_strobes",   32'({mem_read, mem_write}), 32'd0);
    check_eq("late_resp_out_data",  32'(out_data),  32'h0);
    check_eq("abort_no_write",      32'(wr_n - wbase), 32'd0);

    // ---- normal service resumes after the abort ----
    send(4'b0101, 16'h0000, 16'h0000);
    wait_out(20, lat);
    check_eq("post_rst_latency", 32'(lat),      32'd1);
    check_eq("post_rst_data",    32'(out_data), 32'h0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
